// File: rtl/flash_ctrl.sv
// Countdown display flasher: classifies a packed-BCD count into NORMAL/WARN/EXPIRED,
// blinks the digit enables at a state-dependent rate and blanks leading zeros.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_NORMAL  | count above warning threshold, digits steady on
// ST_WARN    | 0 < count <= threshold, blink 0.5 s on / 0.5 s off
// ST_EXPIRED | count is zero, blink 1 s on / 1 s off, one-shot expired pulse
module flash_ctrl #(
    parameter int                    DIGITS     = 4,
    parameter int                    HALF_TICKS = 50000000,
    parameter logic [4*DIGITS-1:0]   WARN_BCD   = 16'h0180
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*DIGITS-1:0]     bcd_in,
    input  logic                    blink_en,
    input  logic                    lzb_en,
    output logic [DIGITS-1:0]       en_7seg,
    output logic [1:0]              state,
    output logic                    expired
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_WARN    = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    localparam int             PW        = (HALF_TICKS > 2) ? $clog2(HALF_TICKS) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(HALF_TICKS - 1);

    state_t              state_q;
    state_t              state_n;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_n;
    logic [1:0]          phase_q;
    logic [1:0]          phase_n;
    logic                first_q;
    logic                blink_on;
    logic                nz_seen;
    logic [DIGITS-1:0]   shown;
    logic [DIGITS-1:0]   en_n;
    logic                expired_n;

    always_comb begin
        if (bcd_in == '0)
            state_n = ST_EXPIRED;
        else if (bcd_in > WARN_BCD)
            state_n = ST_NORMAL;
        else
            state_n = ST_WARN;

        // A state change restarts the blink timebase so the new state opens with an ON interval.
        presc_n = '0;
        phase_n = 2'd0;
        if (state_n == state_q) begin
            if (presc_q == PRESC_MAX) begin
                presc_n = '0;
                phase_n = phase_q + 2'd1;
            end else begin
                presc_n = presc_q + 1'b1;
                phase_n = phase_q;
            end
        end

        blink_on = 1'b1;
        if (blink_en) begin
            case (state_n)
                ST_WARN:    blink_on = ~phase_n[0];
                ST_EXPIRED: blink_on = ~phase_n[1];
                default:    blink_on = 1'b1;
            endcase
        end

        nz_seen = 1'b0;
        shown   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen  = nz_seen | (bcd_in[4*i +: 4] != 4'd0);
            shown[i] = ~lzb_en | (i == 0) | nz_seen;
        end
        en_n = shown & {DIGITS{blink_on}};

        expired_n = (state_n == ST_EXPIRED) && (state_q != ST_EXPIRED) && !first_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            presc_q <= '0;
            phase_q <= 2'd0;
            first_q <= 1'b1;
            en_7seg <= '1;
            expired <= 1'b0;
        end else begin
            state_q <= state_n;
            presc_q <= presc_n;
            phase_q <= phase_n;
            first_q <= 1'b0;
            en_7seg <= en_n;
            expired <= expired_n;
        end
    end

    assign state = state_q;

endmodule

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits and of display enables.
REQ-002 SHALL have parameter HALF_TICKS, default 50000000: clk cycles per 0.5 s blink step, legal range >= 2.
REQ-003 SHALL have parameter WARN_BCD, default 16'h0180 zero-extended to 4*DIGITS bits: packed-BCD warning threshold.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port bcd_in, input, 4*DIGITS bits: packed BCD count, digit 0 in bits [3:0].
REQ-007 SHALL have port blink_en, input, 1 bit: 1 enables blinking; 0 holds all shown digits steady on.
REQ-008 SHALL have port lzb_en, input, 1 bit: 1 enables leading-zero blanking.
REQ-009 SHALL have port en_7seg, output, DIGITS bits: registered per-digit display enable, 1 = lit.
REQ-010 SHALL have port state, output, 2 bits: registered state, 00 NORMAL, 01 WARN, 10 EXPIRED.
REQ-011 SHALL have port expired, output, 1 bit: registered one-cycle pulse on entry to EXPIRED.

Function
REQ-012 SHALL decode next state each cycle: bcd_in > WARN_BCD gives NORMAL, 0 < bcd_in <= WARN_BCD gives WARN, bcd_in == 0 gives EXPIRED.
REQ-013 SHALL compare bcd_in as an unsigned binary vector; digits > 9 are not checked and are compared as-is.
REQ-014 SHALL register state, en_7seg and expired together, so an en_7seg or state response follows a bcd_in change by exactly 1 cycle.
REQ-015 SHALL run a prescaler counting 0..HALF_TICKS-1 with wrap to 0; the wrap cycle produces a step.
REQ-016 SHALL advance a 2-bit phase counter, wrapping 3 to 0, on each step.
REQ-017 SHALL clear both prescaler and phase to 0 on the edge where the registered state changes value.
REQ-018 SHALL set blink-on as follows: NORMAL always on; WARN on when phase[0]==0 (0.5 s on / 0.5 s off); EXPIRED on when phase[1]==0 (1 s on / 1 s off).
REQ-019 SHALL treat blink-on as 1 in all states when blink_en==0; the prescaler and phase keep running.
REQ-020 SHALL mark digit i shown when lzb_en==0, or i==0, or any digit j>=i of bcd_in is non-zero.
REQ-021 SHALL drive en_7seg[i] = shown(i) AND blink-on.
REQ-022 SHALL compute en_7seg on a state-change edge with phase 0, so the first interval in the new state is ON.
REQ-023 SHALL pulse expired high for exactly 1 cycle when the registered state goes from NORMAL or WARN to EXPIRED.
REQ-024 SHALL NOT pulse expired while remaining in EXPIRED, nor on the first evaluation after reset.
REQ-025 SHALL NOT stretch or repeat the expired pulse; a bcd_in that returns to non-zero and then to 0 yields a new pulse.

Reset
REQ-026 SHALL, on rst==1 at a clk edge, set en_7seg all ones, state=00, expired=0, prescaler=0, phase=0, and the first-cycle flag set.
REQ-027 SHALL give rst priority over all other activity, including mid-blink and mid-pulse; expired is forced to 0.
REQ-028 SHALL, on the first edge after rst deasserts, decode bcd_in normally, with expired suppressed per REQ-024.

Verification
REQ-029 SHALL cover reset with DIGITS=4, HALF_TICKS=4, bcd_in=16'h0000 -> en_7seg=4'b1111, state=00; after release, state=10 and expired stays 0.
REQ-030 SHALL cover bcd_in=16'h0181 with lzb_en=1 -> state=00 and en_7seg=4'b0111, steady for >= 20 cycles.
REQ-031 SHALL cover bcd_in 16'h0181 -> 16'h0180 -> state=01 one cycle later; en_7seg=0111 for 4 cycles, then 0000 for 4 cycles, repeating.
REQ-032 SHALL cover bcd_in 16'h0001 -> 16'h0000 -> state=10 and expired=1 for 1 cycle; en_7seg=0001 for 8 cycles, then 0000 for 8 cycles.
REQ-033 SHALL cover EXPIRED with blink_en=0 -> en_7seg steady 0001; then toggle lzb_en=0 -> en_7seg=1111 one cycle later.
REQ-034 SHALL cover rst asserted during the expired pulse cycle and mid-WARN off-phase -> all outputs at reset values next edge; no extra expired pulse.
